// File: rtl/cla_divider16_pkg.sv
// cla_divider16_pkg
//   Shared constants and types for the 16-bit restoring divider.
//   DIV_W   operand/result width
//   CNT_W   iteration counter width (16 iterations)
//   state_e divider FSM encoding
package cla_divider16_pkg;

  localparam int DIV_W = 16;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_divider16_if.sv
// cla_divider16_if
//   Operand and result handshake bundle for cla_divider16.
//   in_valid/in_ready   operand pair handshake (dividend, divisor)
//   out_valid/out_ready result handshake (quotient, remainder, div_by_zero)
//   master: producer of operands / consumer of results
//   slave : the divider
interface cla_divider16_if;
  import cla_divider16_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/cla_divider16_cla.sv
// carry_lookahead_adder16
//   16-bit adder built from four 4-bit lookahead groups; group carries
//   are chained from the group generate/propagate terms.
//   a, b  addends
//   cin   carry in
//   sum   a + b + cin (low 16 bits)
//   cout  carry out
module carry_lookahead_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic [4:0] cg;
    logic [3:0] gv;
    logic [3:0] pv;
    logic [3:0] ci;
    logic       grp_g;
    logic       grp_p;
    sum   = '0;
    cg    = '0;
    cg[0] = cin;
    for (int i = 0; i < 4; i++) begin
      gv    = g[4*i +: 4];
      pv    = p[4*i +: 4];
      ci[0] = cg[i];
      ci[1] = gv[0] | (pv[0] & cg[i]);
      ci[2] = gv[1] | (pv[1] & gv[0]) | (pv[1] & pv[0] & cg[i]);
      ci[3] = gv[2] | (pv[2] & gv[1]) | (pv[2] & pv[1] & gv[0])
            | (pv[2] & pv[1] & pv[0] & cg[i]);
      grp_g = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1])
            | (pv[3] & pv[2] & pv[1] & gv[0]);
      grp_p = &pv;
      sum[4*i +: 4] = pv ^ ci;
      cg[i+1] = grp_g | (grp_p & cg[i]);
    end
    cout = cg[4];
  end

endmodule

// File: rtl/cla_divider16.sv
// cla_divider16
//   Sequential 16-bit unsigned restoring divider, one quotient bit per
//   clock. The trial subtract reuses carry_lookahead_adder16 as T + ~D + 1.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  cla_divider16_if.slave: operand and result handshakes
//   DBZ_QUOTIENT  quotient reported when the divisor is zero
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operand pair
//   RUN   | 16 shift/subtract iterations, cnt counts 0..15
//   DONE  | out_valid=1, result held until out_ready
module cla_divider16
  import cla_divider16_pkg::*;
#(
  parameter logic [DIV_W-1:0] DBZ_QUOTIENT = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst,
  cla_divider16_if.slave  bus
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] q_q, q_d;
  logic [DIV_W:0]   r_q, r_d;
  logic [DIV_W-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [DIV_W:0]   t;
  logic [DIV_W-1:0] diff;
  logic             nb;
  logic             fits;
  logic             unused_r_msb;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign t = {r_q[DIV_W-1:0], q_q[DIV_W-1]};

  carry_lookahead_adder16 u_sub (
    .a    (t[DIV_W-1:0]),
    .b    (~d_q),
    .cin  (1'b1),
    .sum  (diff),
    .cout (nb)
  );

  // No borrow from the low 16 bits, or a 17th bit that already exceeds D.
  assign fits = t[DIV_W] | nb;

  // R never exceeds D after an iteration, so its top bit is never read back.
  assign unused_r_msb = r_q[DIV_W];

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          d_d   = bus.divisor;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            q_d     = DBZ_QUOTIENT;
            r_d     = {1'b0, bus.dividend};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = bus.dividend;
            r_d     = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (fits) begin
          r_d = {1'b0, diff};
          q_d = {q_q[DIV_W-2:0], 1'b1};
        end else begin
          r_d = t;
          q_d = {q_q[DIV_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == '1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          dbz_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q[DIV_W-1:0];
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_cla_divider16.sv
// tb_cla_divider16
//   Directed literal cases plus randomized traffic for cla_divider16,
//   checked against an arithmetic reference model (/ and %).
module tb_cla_divider16;
  import cla_divider16_pkg::*;

  localparam int NOPS = 2000;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_divider16_if bus ();

  cla_divider16 #(.DBZ_QUOTIENT(16'hFFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t head;
  bit   prev_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t x;
    if (b == 16'd0) begin
      x.q = 16'hFFFF; x.r = a; x.dbz = 1'b1;
    end else begin
      x.q = a / b; x.r = a % b; x.dbz = 1'b0;
    end
    return x;
  endfunction

  // Scoreboard: record accepted operands, check every cycle a result is shown.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.dividend, bus.divisor));
      if (prev_hold)
        chk("hold_out_valid", bus.out_valid, 1);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got q=%0h r=%0h with no operand pending",
                   bus.quotient, bus.remainder);
        end else begin
          head = exp_q[0];
          chk("model_quotient", bus.quotient, head.q);
          chk("model_remainder", bus.remainder, head.r);
          chk("model_dbz", bus.div_by_zero, head.dbz);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Directed operation with literal expectations; hold_cyc cycles of
  // backpressure with a competing in_valid before the result is taken.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edbz, input int elat, input int hold_cyc);
    int lat;
    bit seen;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.dividend = a; bus.divisor = b; bus.out_ready = 1'b0;
    @(negedge clk);
    chk("accept_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.dividend = 16'($urandom); bus.divisor = 16'($urandom);
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    chk("latency", lat, elat);
    chk("lit_quotient", bus.quotient, eq);
    chk("lit_remainder", bus.remainder, er);
    chk("lit_dbz", bus.div_by_zero, edbz);
    for (int i = 0; i < hold_cyc; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.dividend = 16'($urandom); bus.divisor = 16'($urandom);
      @(negedge clk);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_quotient", bus.quotient, eq);
      chk("hold_remainder", bus.remainder, er);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_quotient_kept", bus.quotient, eq);
    chk("idle_remainder_kept", bus.remainder, er);
    chk("idle_dbz_clear", bus.div_by_zero, 0);
  endtask

  function automatic logic [15:0] rand_dividend();
    case ($urandom_range(0, 7))
      0:       return 16'd0;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rand_divisor();
    case ($urandom_range(0, 7))
      0:       return 16'd0;
      1:       return 16'($urandom_range(1, 15));
      2:       return 16'hFFFF;
      3:       return 16'($urandom_range(1, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int  ops_done;
    int  gap;
    bit  presenting;
    bit  accepted_last;
    bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);

    do_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, 0);
    do_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16, 0);
    do_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 16, 0);
    do_op(16'd3, 16'hFFFF, 16'd0, 16'd3, 1'b0, 16, 0);
    do_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0, 0);
    do_op(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 16, 10);
    do_op(16'd77, 16'd0, 16'hFFFF, 16'd77, 1'b1, 0, 10);

    // Reset after eight iterations drops the operation.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.dividend = 16'd12345; bus.divisor = 16'd67;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_quotient", bus.quotient, 0);
    chk("midrst_remainder", bus.remainder, 0);
    do_op(16'd40000, 16'd123, 16'd325, 16'd25, 1'b0, 16, 0);

    // Random traffic with gaps and backpressure.
    ops_done = 0; gap = 0; presenting = 1'b0; accepted_last = 1'b0;
    for (int cyc = 0; cyc < 70000 && ops_done < NOPS; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (presenting && accepted_last) begin
        presenting = 1'b0;
        ops_done++;
        gap = $urandom_range(0, 2);
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
      end
      if (!presenting && ops_done < NOPS) begin
        if (gap > 0) begin
          gap--;
          bus.dividend = 16'($urandom);
          bus.divisor  = 16'($urandom);
        end else begin
          presenting = 1'b1;
          bus.in_valid = 1'b1;
          bus.dividend = rand_dividend();
          bus.divisor  = rand_divisor();
        end
      end
      @(negedge clk);
      accepted_last = bus.in_valid && bus.in_ready;
    end
    chk("random_ops_completed", ops_done, NOPS);

    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
